// File: rtl/demux_router_if.sv
// Bundle of signals between the demux router and its environment.
//   in_valid/in_ready/in_sel/in_data : single upstream valid/ready stream
//   out_valid/out_ready              : per-destination handshake
//   out_data                         : per-destination head payload
//   out_level                        : per-destination FIFO occupancy, 0..DEPTH
// The slave modport is the router; the master modport is whatever drives the
// upstream stream and the downstream ready lines.
interface demux_router_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned SEL_WIDTH   = $clog2(NUM_OUTPUTS),
  parameter int unsigned DEPTH       = 2
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_WIDTH-1:0]   in_sel;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [NUM_OUTPUTS-1:0] out_valid;
  logic [NUM_OUTPUTS-1:0] out_ready;
  logic [DATA_WIDTH-1:0]  out_data  [NUM_OUTPUTS];
  logic [LVL_W-1:0]       out_level [NUM_OUTPUTS];

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_level
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_level
  );
endinterface

// File: rtl/demux_router.sv
// demux_router: routes one valid/ready stream to one of NUM_OUTPUTS consumers
// selected per beat by in_sel. Each destination owns a DEPTH-entry FIFO so a
// stalled consumer only blocks beats addressed to it.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   sif        : demux_router_if.slave (upstream stream + per-output drain)
//   err_o      : (DEMUX_ROUTER_ERR_EN only) one-cycle pulse after an
//                out-of-range beat is accepted
//   err_sel_o  : (DEMUX_ROUTER_ERR_EN only) in_sel of the last such beat
// Optional feature macro: DEMUX_ROUTER_ERR_EN. Without it out-of-range beats
// are accepted and silently dropped.
module demux_router #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned SEL_WIDTH   = $clog2(NUM_OUTPUTS),
  parameter int unsigned DEPTH       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef DEMUX_ROUTER_ERR_EN
  output logic                 err_o,
  output logic [SEL_WIDTH-1:0] err_sel_o,
`endif
  demux_router_if.slave        sif
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned SEL_SPAN = 1 << SEL_WIDTH;

  logic [PW-1:0]          wr_q    [NUM_OUTPUTS];
  logic [PW-1:0]          wr_d    [NUM_OUTPUTS];
  logic [PW-1:0]          rd_q    [NUM_OUTPUTS];
  logic [PW-1:0]          rd_d    [NUM_OUTPUTS];
  logic [PW-1:0]          level_c [NUM_OUTPUTS];
  logic [DATA_WIDTH-1:0]  mem_q   [NUM_OUTPUTS][DEPTH];
  logic [SEL_SPAN-1:0]    full_c;
  logic [NUM_OUTPUTS-1:0] valid_c;
  logic [NUM_OUTPUTS-1:0] push_c;
  logic [NUM_OUTPUTS-1:0] pop_c;
  logic                   ready_c;
  logic                   accept_c;

  // Per-port occupancy and full flag from the extra-MSB pointer scheme.
  // full_c is padded to the whole in_sel range; padding bits stay 0 so an
  // out-of-range select always reads ready.
  always_comb begin
    level_c = '{default: '0};
    full_c  = '0;
    valid_c = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      level_c[i] = wr_q[i] - rd_q[i];
      valid_c[i] = (level_c[i] != '0);
      full_c[i]  = (wr_q[i][AW] != rd_q[i][AW]) &&
                   (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
    end
  end

  // Readiness depends only on registered state and in_sel, never on out_ready.
  assign ready_c  = ~full_c[sif.in_sel];
  assign accept_c = sif.in_valid & ready_c;

  // Push/pop decode and pointer advance.
  always_comb begin
    push_c = '0;
    pop_c  = '0;
    wr_d   = wr_q;
    rd_d   = rd_q;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      push_c[i] = accept_c && (sif.in_sel == SEL_WIDTH'(i));
      pop_c[i]  = valid_c[i] & sif.out_ready[i];
      wr_d[i]   = wr_q[i] + PW'(push_c[i]);
      rd_d[i]   = rd_q[i] + PW'(pop_c[i]);
    end
  end

  // FIFO storage and pointers; storage is cleared so out_data reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        wr_q[i] <= wr_d[i];
        rd_q[i] <= rd_d[i];
        if (push_c[i]) begin
          mem_q[i][wr_q[i][AW-1:0]] <= sif.in_data;
        end
      end
    end
  end

  assign sif.in_ready  = ready_c;
  assign sif.out_valid = valid_c;

  // Head entry and occupancy per destination.
  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_out
    assign sif.out_data[g]  = mem_q[g][rd_q[g][AW-1:0]];
    assign sif.out_level[g] = level_c[g];
  end

`ifdef DEMUX_ROUTER_ERR_EN
  logic                 in_range_c;
  logic                 err_q;
  logic [SEL_WIDTH-1:0] err_sel_q;

  assign in_range_c = (32'(sif.in_sel) < NUM_OUTPUTS);

  // Out-of-range beats are always accepted, so in_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_sel_q <= '0;
    end else begin
      err_q <= sif.in_valid && !in_range_c;
      if (sif.in_valid && !in_range_c) begin
        err_sel_q <= sif.in_sel;
      end
    end
  end

  assign err_o     = err_q;
  assign err_sel_o = err_sel_q;
`endif
endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;
  localparam int unsigned DW = 32;
  localparam int unsigned NO = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned DP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_router_if #(.DATA_WIDTH(DW), .NUM_OUTPUTS(NO), .SEL_WIDTH(SW), .DEPTH(DP)) bus ();
  demux_router_if #(.DATA_WIDTH(DW), .NUM_OUTPUTS(3), .SEL_WIDTH(SW), .DEPTH(DP)) bus3 ();

`ifdef DEMUX_ROUTER_ERR_EN
  logic          err4, err3;
  logic [SW-1:0] esel4, esel3;
`endif

  demux_router #(.DATA_WIDTH(DW), .NUM_OUTPUTS(NO), .SEL_WIDTH(SW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DEMUX_ROUTER_ERR_EN
    .err_o     (err4),
    .err_sel_o (esel4),
`endif
    .sif       (bus)
  );

  demux_router #(.DATA_WIDTH(DW), .NUM_OUTPUTS(3), .SEL_WIDTH(SW), .DEPTH(DP)) dut3 (
    .clk       (clk),
    .rst       (rst),
`ifdef DEMUX_ROUTER_ERR_EN
    .err_o     (err3),
    .err_sel_o (esel3),
`endif
    .sif       (bus3)
  );

  typedef struct {
    logic          v;
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic [NO-1:0] rdy;
    logic          exp_rdy;
  } vec_t;

  vec_t          tbl [$];
  logic [DW-1:0] sb  [NO][$];
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void add(input logic v, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                              input logic [NO-1:0] r, input logic er);
    vec_t t;
    t.v = v; t.sel = sel; t.data = d; t.rdy = r; t.exp_rdy = er;
    tbl.push_back(t);
  endfunction

  // Drive one cycle, compare at the falling edge, then advance the scoreboard
  // with this cycle's pops and (if expected to be accepted) the push.
  task automatic apply(input vec_t t);
    bus.in_valid  = t.v;
    bus.in_sel    = t.sel;
    bus.in_data   = t.data;
    bus.out_ready = t.rdy;
    @(negedge clk);
    chk($sformatf("in_ready sel=%0d", t.sel), DW'(bus.in_ready), DW'(t.exp_rdy));
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("out_valid[%0d]", i), DW'(bus.out_valid[i]), DW'(sb[i].size() != 0));
      chk($sformatf("out_level[%0d]", i), DW'(bus.out_level[i]), DW'(sb[i].size()));
      if (sb[i].size() != 0) chk($sformatf("out_data[%0d]", i), bus.out_data[i], sb[i][0]);
    end
    for (int i = 0; i < NO; i++) begin
      if (sb[i].size() != 0 && t.rdy[i]) void'(sb[i].pop_front());
    end
    if (t.v && t.exp_rdy) sb[t.sel].push_back(t.data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;

    // single beat to port 2, held while consumer stalls
    add(1, 2, 32'hDEADBEEF, 4'b0000, 1);
    add(0, 2, 32'h0,        4'b0000, 1);
    add(0, 2, 32'h0,        4'b0000, 1);
    add(0, 2, 32'h0,        4'b0100, 1);
    // port 1 fills at DEPTH=2, third beat waits until the cycle after a pop
    add(1, 1, 32'h1, 4'b0000, 1);
    add(1, 1, 32'h2, 4'b0000, 1);
    add(1, 1, 32'h3, 4'b0000, 0);
    add(1, 1, 32'h3, 4'b0010, 0);
    add(1, 1, 32'h3, 4'b0000, 1);
    add(0, 1, 32'h0, 4'b0010, 0);
    add(0, 1, 32'h0, 4'b0010, 1);
    // port 0 stalled full, port 3 keeps flowing
    add(1, 0, 32'hA0, 4'b0000, 1);
    add(1, 0, 32'hA1, 4'b0000, 1);
    for (int k = 0; k < 3; k++) begin
      add(1, 0, 32'hA2,             4'b1000, 0);
      add(1, 3, 32'hB0 + DW'(k),    4'b1000, 1);
    end
    add(0, 0, 32'h0,  4'b1001, 0);
    add(1, 0, 32'hA2, 4'b0001, 1);
    add(0, 0, 32'h0,  4'b0001, 1);
    // port 2 at level 1 with push+pop every cycle, pointers wrap several times
    add(1, 2, 32'hC0, 4'b0000, 1);
    for (int k = 1; k <= 10; k++) add(1, 2, 32'hC0 + DW'(k), 4'b0100, 1);
    add(0, 2, 32'h0, 4'b0100, 1);
    add(0, 0, 32'h0, 4'b0000, 1);

    bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0; bus.out_ready = '0;
    bus3.in_valid = 1'b0; bus3.in_sel = '0; bus3.in_data = '0; bus3.out_ready = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset in_ready", DW'(bus.in_ready), DW'(1'b1));
    chk("reset out_valid", DW'(bus.out_valid), DW'(4'b0000));
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("reset out_level[%0d]", i), DW'(bus.out_level[i]), DW'(0));
      chk($sformatf("reset out_data[%0d]", i), bus.out_data[i], DW'(0));
    end
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k]);
      if (k == 0) begin
        chk("t1 out_valid vector", DW'(bus.out_valid), DW'(4'b0100));
        chk("t1 out_level[2]", DW'(bus.out_level[2]), DW'(1));
      end
    end

    // out-of-range select on a 3-output instance
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_data = 32'h5A5A5A5A;
    @(negedge clk);
    chk("oor in_ready", DW'(bus3.in_ready), DW'(1'b1));
    @(posedge clk);
    #1 bus3.in_valid = 1'b0;
    @(negedge clk);
    chk("oor out_valid", DW'(bus3.out_valid), DW'(3'b000));
    for (int i = 0; i < 3; i++) chk($sformatf("oor out_level[%0d]", i), DW'(bus3.out_level[i]), DW'(0));
`ifdef DEMUX_ROUTER_ERR_EN
    chk("err_o pulse", DW'(err3), DW'(1'b1));
    chk("err_sel_o", DW'(esel3), DW'(2'd3));
    @(posedge clk);
    @(negedge clk);
    chk("err_o cleared", DW'(err3), DW'(1'b0));
    chk("err_sel_o held", DW'(esel3), DW'(2'd3));
    chk("err_o quiet on 4-port", DW'(err4), DW'(1'b0));
`endif
    @(posedge clk);
    #1 bus3.in_valid = 1'b1; bus3.in_sel = 2'd2; bus3.in_data = 32'h00C0FFEE;
    @(negedge clk);
    chk("3port in_ready", DW'(bus3.in_ready), DW'(1'b1));
    @(posedge clk);
    #1 bus3.in_valid = 1'b0;
    @(negedge clk);
    chk("3port out_valid", DW'(bus3.out_valid), DW'(3'b100));
    chk("3port out_data[2]", bus3.out_data[2], 32'h00C0FFEE);
    @(posedge clk);
    #1;

    // reset with every FIFO non-empty and a beat in flight
    for (int i = 0; i < NO; i++) begin
      t.v = 1'b1; t.sel = SW'(i); t.data = 32'hE0 + DW'(i); t.rdy = '0; t.exp_rdy = 1'b1;
      apply(t);
    end
    chk("pre-reset out_valid", DW'(bus.out_valid), DW'(4'b1111));
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'hBAD;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NO; i++) sb[i].delete();
    t.v = 1'b1; t.sel = 2'd0; t.data = 32'hF0; t.rdy = '0; t.exp_rdy = 1'b1;
    apply(t);
    chk("post-reset beat alone", DW'(bus.out_valid), DW'(4'b0001));
    chk("post-reset beat data", bus.out_data[0], 32'hF0);
    t.v = 1'b0; t.rdy = 4'b0001;
    apply(t);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
